// File: rtl/spi_rom_reader.sv
// Serial-ROM READ sequencer: drives an SPI register port (cmd/status/tx/rx) and streams
// the payload bytes out on a ready/valid interface; push and pop interleave to bound rx occupancy.
module spi_rom_reader #(
  parameter logic [1:0] FREQ_SEL     = 2'd0,
  parameter logic [7:0] READ_CMD     = 8'h03,
  parameter int         LEN_W        = 8,
  parameter int         MAX_INFLIGHT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       bus2ip_data,
  output logic [1:0]       bus2ip_addr,
  output logic             bus2ip_wr,
  output logic             bus2ip_rd,
  input  logic [7:0]       ip2bus_data,
  input  logic             ip2bus_rdack,
  input  logic             ip2bus_wrack
);

  localparam int CW = LEN_W + 1;
  localparam logic [CW-1:0] MAX_INF = CW'(MAX_INFLIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_POLL, S_PUSH, S_POP, S_OUT, S_DONE
  } state_e;

  state_e          state_q, state_d, after_st;
  logic            rel_q, rel_d;
  logic [23:0]     addr_q, addr_d;
  logic [CW-1:0]   total_q, total_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic            rx_empty_q, rx_empty_d;
  logic            tx_full_q, tx_full_d;
  logic [7:0]      byte_q, byte_d;

  logic            wr_st, rd_st, ack, req_ack, rel_exit;
  logic [7:0]      tx_byte;

  assign wr_st    = (state_q == S_CFG) || (state_q == S_PUSH);
  assign rd_st    = (state_q == S_POLL) || (state_q == S_POP);
  assign ack      = wr_st ? ip2bus_wrack : ip2bus_rdack;
  assign req_ack  = (wr_st || rd_st) && !rel_q && ack;
  // A new access may only begin once the previous ack has been seen low.
  assign rel_exit = (wr_st || rd_st) && rel_q && !ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    after_st = S_POLL;
    if (state_q == S_POP && rx_cnt_q > CW'(4)) begin
      after_st = S_OUT;
    end else if (state_q == S_POLL) begin
      if (!rx_empty_q && rx_cnt_q < total_q)
        after_st = S_POP;
      else if (!tx_full_q && tx_cnt_q < total_q && (tx_cnt_q - rx_cnt_q) < MAX_INF)
        after_st = S_PUSH;
      else if (rx_cnt_q == total_q)
        after_st = S_DONE;
    end
  end

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    case (state_q)
      S_IDLE: if (start) state_d = (len == '0) ? S_DONE : S_CFG;
      S_CFG, S_POLL, S_PUSH, S_POP: begin
        if (req_ack) begin
          rel_d = 1'b1;
        end else if (rel_exit) begin
          rel_d   = 1'b0;
          state_d = after_st;
        end
      end
      S_OUT:  if (out_ready) state_d = S_POLL;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      total_q    <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      rx_empty_q <= 1'b1;
      tx_full_q  <= 1'b0;
      byte_q     <= '0;
    end else begin
      addr_q     <= addr_d;
      total_q    <= total_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_empty_q <= rx_empty_d;
      tx_full_q  <= tx_full_d;
      byte_q     <= byte_d;
    end
  end

  always_comb begin
    addr_d     = addr_q;
    total_d    = total_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    rx_empty_d = rx_empty_q;
    tx_full_d  = tx_full_q;
    byte_d     = byte_q;
    if (state_q == S_IDLE && start) begin
      addr_d   = addr;
      total_d  = {1'b0, len} + CW'(4);
      tx_cnt_d = '0;
      rx_cnt_d = '0;
    end
    if (req_ack) begin
      case (state_q)
        S_POLL: begin
          rx_empty_d = ip2bus_data[0];
          tx_full_d  = ip2bus_data[3];
        end
        S_PUSH: tx_cnt_d = tx_cnt_q + CW'(1);
        S_POP: begin
          rx_cnt_d = rx_cnt_q + CW'(1);
          byte_d   = ip2bus_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    if (tx_cnt_q == CW'(0))      tx_byte = READ_CMD;
    else if (tx_cnt_q == CW'(1)) tx_byte = addr_q[23:16];
    else if (tx_cnt_q == CW'(2)) tx_byte = addr_q[15:8];
    else if (tx_cnt_q == CW'(3)) tx_byte = addr_q[7:0];
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    out_valid   = (state_q == S_OUT);
    out_data    = byte_q;
    bus2ip_wr   = wr_st && !rel_q;
    bus2ip_rd   = rd_st && !rel_q;
    bus2ip_addr = 2'd0;
    bus2ip_data = 9'd0;
    if (!rel_q) begin
      case (state_q)
        S_CFG:  bus2ip_data = {7'd0, FREQ_SEL};
        S_POLL: bus2ip_addr = 2'd1;
        S_PUSH: begin
          bus2ip_addr = 2'd2;
          // bit 8 releases chip-select after the final byte of the frame
          bus2ip_data = {(tx_cnt_q == total_q - CW'(1)), tx_byte};
        end
        S_POP:  bus2ip_addr = 2'd3;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_reader.sv
// Bench for spi_rom_reader: SPI register-port model plus scoreboard queues for the
// cmd write, tx FIFO writes and output byte stream.
module tb_spi_rom_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] addr = '0;
  logic [7:0]  len = '0;
  logic        busy, done, out_valid, bus2ip_wr, bus2ip_rd;
  logic        out_ready = 1'b0;
  logic        ip2bus_rdack = 1'b0;
  logic        ip2bus_wrack = 1'b0;
  logic [7:0]  out_data;
  logic [7:0]  ip2bus_data = '0;
  logic [8:0]  bus2ip_data;
  logic [1:0]  bus2ip_addr;

  int total = 0;
  int bad = 0;

  logic [8:0] exp_cmd[$];
  logic [8:0] exp_tx[$];
  logic [7:0] exp_out[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_next = 8'h10;
  bit         force_full = 1'b0;
  bit         strobe_seen = 1'b0;
  int         poll_cnt = 0;
  int         tx_in_full = 0;
  int         max_infl = 0;
  int         stall_left = 0;
  int         wait_cnt = 0;
  bit         held_vld = 1'b0;
  logic [7:0] held = '0;

  always #5 clk = ~clk;

  spi_rom_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .len(len),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .bus2ip_data(bus2ip_data), .bus2ip_addr(bus2ip_addr),
    .bus2ip_wr(bus2ip_wr), .bus2ip_rd(bus2ip_rd), .ip2bus_data(ip2bus_data),
    .ip2bus_rdack(ip2bus_rdack), .ip2bus_wrack(ip2bus_wrack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic do_write();
    if (bus2ip_addr == 2'd0) begin
      if (exp_cmd.size() == 0) unexpected("cmd_write", bus2ip_data);
      else check("cmd_write", bus2ip_data, exp_cmd.pop_front());
    end else if (bus2ip_addr == 2'd2) begin
      if (force_full) tx_in_full++;
      if (exp_tx.size() == 0) unexpected("tx_write", bus2ip_data);
      else check("tx_write", bus2ip_data, exp_tx.pop_front());
      rx_q.push_back(rx_next);
      rx_next++;
      if (rx_q.size() > max_infl) max_infl = rx_q.size();
    end else begin
      unexpected("write_addr", bus2ip_addr);
    end
  endtask

  task automatic do_read();
    if (bus2ip_addr == 2'd1) begin
      ip2bus_data = {4'b0000, force_full, 1'b1, (rx_q.size() >= 16), (rx_q.size() == 0)};
      poll_cnt++;
    end else if (bus2ip_addr == 2'd3) begin
      if (rx_q.size() == 0) begin
        unexpected("rx_read_empty", 0);
        ip2bus_data = 8'h00;
      end else begin
        ip2bus_data = rx_q.pop_front();
      end
    end else begin
      unexpected("read_addr", bus2ip_addr);
    end
  endtask

  // SPI register-port model: ack after 1 cycle (3 for rx FIFO reads), drop when strobe drops.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ip2bus_wrack = 1'b0;
        ip2bus_rdack = 1'b0;
        wait_cnt = 0;
        rx_q.delete();
      end else begin
        if (bus2ip_wr || bus2ip_rd) strobe_seen = 1'b1;
        if (bus2ip_wr && bus2ip_rd) check("strobe_excl", 1, 0);
        if (ip2bus_wrack && !bus2ip_wr) ip2bus_wrack = 1'b0;
        if (ip2bus_rdack && !bus2ip_rd) ip2bus_rdack = 1'b0;
        if ((bus2ip_wr && !ip2bus_wrack) || (bus2ip_rd && !ip2bus_rdack)) begin
          wait_cnt++;
          if (wait_cnt >= ((bus2ip_rd && bus2ip_addr == 2'd3) ? 3 : 1)) begin
            wait_cnt = 0;
            if (bus2ip_wr) begin
              do_write();
              ip2bus_wrack = 1'b1;
            end else begin
              do_read();
              ip2bus_rdack = 1'b1;
            end
          end
        end
      end
    end
  end

  // Output monitor: applies requested stall, then pops and compares on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          if (!held_vld) begin
            held = out_data;
            held_vld = 1'b1;
          end else begin
            check("stall_data", out_data, held);
          end
          check("stall_no_bus", {bus2ip_wr, bus2ip_rd}, 0);
          stall_left--;
        end else begin
          out_ready = 1'b1;
          held_vld = 1'b0;
          if (exp_out.size() == 0) unexpected("out_byte", out_data);
          else check("out_byte", out_data, exp_out.pop_front());
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  task automatic issue_job(input logic [23:0] a, input logic [7:0] l);
    logic [8:0] w;
    rx_next = 8'h10;
    if (l != 0) exp_cmd.push_back(9'h000);
    for (int i = 0; i < int'(l) + 4 && l != 0; i++) begin
      case (i)
        0: w[7:0] = 8'h03;
        1: w[7:0] = a[23:16];
        2: w[7:0] = a[15:8];
        3: w[7:0] = a[7:0];
        default: w[7:0] = 8'h00;
      endcase
      w[8] = (i == int'(l) + 3);
      exp_tx.push_back(w);
    end
    for (int i = 0; i < int'(l); i++) exp_out.push_back(8'h14 + 8'(i));
    @(negedge clk);
    addr = a;
    len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    check("tx_left", exp_tx.size(), 0);
    check("out_left", exp_out.size(), 0);
    check("cmd_left", exp_cmd.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out"}, {out_valid, out_data}, 0);
    check({tag, "_strobes"}, {bus2ip_wr, bus2ip_rd}, 0);
    check({tag, "_bus"}, {bus2ip_addr, bus2ip_data}, 0);
  endtask

  initial begin
    int cyc;
    bit found;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // len=0: straight to DONE, no bus access
    strobe_seen = 1'b0;
    issue_job(24'h000123, 8'd0);
    wait_done(cyc);
    check("len0_latency_ok", (cyc <= 2), 1);
    @(negedge clk);
    check("len0_busy_drop", busy, 0);
    check("len0_no_strobe", strobe_seen, 0);

    // basic len=2 job
    issue_job(24'h123456, 8'd2);
    wait_done(cyc);
    @(negedge clk);
    check("busy_idle", busy, 0);

    // same job with 10-cycle consumer stall on first payload byte
    stall_left = 10;
    issue_job(24'h123456, 8'd2);
    wait_done(cyc);
    check("stall_consumed", stall_left, 0);

    // tx_full held for 20 cycles at job start; len=20
    force_full = 1'b1;
    tx_in_full = 0;
    max_infl = 0;
    poll_cnt = 0;
    issue_job(24'hABCDEF, 8'd20);
    repeat (20) @(negedge clk);
    check("no_tx_while_full", tx_in_full, 0);
    check("poll_repeats", (poll_cnt > 3), 1);
    force_full = 1'b0;
    wait_done(cyc);
    check("inflight_bound", (max_infl <= 8), 1);

    // second start while busy must be ignored
    issue_job(24'h0A0B0C, 8'd3);
    repeat (12) @(negedge clk);
    addr = 24'hFFEEDD;
    len = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    repeat (20) @(negedge clk);
    check("no_second_job", busy, 0);

    // reset while an rx FIFO read strobe is held
    issue_job(24'h123456, 8'd2);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus2ip_rd && bus2ip_addr == 2'd3) found = 1'b1;
    end
    check("rd3_seen", found, 1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    exp_tx.delete();
    exp_out.delete();
    exp_cmd.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue_job(24'h00C0DE, 8'd1);
    wait_done(cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
